reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Sits directly downstream of the reset synchronizer; its rst_i is the synchronizer's active-high synced reset output.
- Gates release on a lock/ready qualifier, such as PLL locked.
- Deasserts NUM_OUTS active-high domain resets one at a time, in index order, with fixed spacing.
- Reasserts all domain resets at once if the qualifier is lost.

Parameters:
- NUM_OUTS, 4: number of sequenced reset outputs; must be ≥1.
- HOLD_CYCLES, 16: minimum cycles all outputs stay asserted after rst_i is sampled low; must be ≥1.
- STAGE_DELAY, 8: cycles between successive output releases; must be ≥1.
- LOCK_TIMEOUT, 1024: WAIT_LOCK cycles before err_o is flagged; used only with the optional feature; must be ≥1.

Ports:
- clk_i  input  1  single system clock.
- rst_i  input  1  synchronous, active-high reset, sampled on rising clk_i.
- lock_i  input  1  release qualifier; already synchronous to clk_i.
- rst_o  output  NUM_OUTS  per-domain active-high resets; bit 0 is released first.
- stage_o  output  $clog2(NUM_OUTS+1)  count of outputs released so far.
- ready_o  output  1  high once every rst_o bit is released.
- err_o  output  1  sticky lock-timeout flag; constant 0 without the optional feature.

Behaviour:
- All state is registered on rising clk_i. rst_i is synchronous and has priority over every other event.
- While rst_i=1:
  - state=HOLD, counter=0.
  - rst_o all ones, stage_o=0, ready_o=0, err_o=0.
- Edge numbering: n counts rising edges after the last edge at which rst_i was sampled 1.
- HOLD:
  - counter increments each edge.
  - At edge n=HOLD_CYCLES, state goes to WAIT_LOCK and counter clears.
  - lock_i is ignored in HOLD.
- WAIT_LOCK:
  - On the first edge with lock_i=1, state goes to RELEASE and counter=0.
  - Otherwise the counter increments, saturating.
- RELEASE:
  - counter increments each edge.
  - At counter==STAGE_DELAY-1: clear rst_o[stage_o], increment stage_o, counter=0.
  - The edge that clears the last bit also sets ready_o=1 and moves state to RUN.
- RUN: outputs are held.
- Timing with lock_i high throughout: rst_o[k] falls at edge n = HOLD_CYCLES + 1 + (k+1)*STAGE_DELAY. Defaults give 25, 33, 41, 49; ready_o rises at 49.
- rst_o bits are released in index order only, never more than one per edge, and are monotonic within a sequence.
- Lock loss: lock_i sampled 0 in RELEASE or RUN means that on the same edge rst_o goes to all ones, stage_o=0, ready_o=0, state=HOLD, counter=0. The full HOLD period then reruns.
- Simultaneous events: rst_i=1 overrides lock loss and release. Lock loss overrides a stage release due on the same edge.
- Counter width: $clog2(max(HOLD_CYCLES, STAGE_DELAY, LOCK_TIMEOUT)+1). No wrap-around; the WAIT_LOCK count saturates.
- Outputs are register-driven with no combinational path from inputs. Latency from lock loss to rst_o assertion is one edge.
- Illegal parameter values (below the stated minimums) cause an elaboration-time $fatal.

Optional Feature:
- Macro: RESET_SEQ_LOCK_TIMEOUT_EN.
- Defined:
  - In WAIT_LOCK, if the counter reaches LOCK_TIMEOUT with lock_i still 0, err_o is set to 1.
  - err_o is sticky: only rst_i clears it. Lock loss does not clear it, and it stays 1 even if lock_i later rises and the sequence completes.
  - State stays WAIT_LOCK and outputs stay asserted until lock_i=1.
- Undefined: no timeout logic is built, err_o is tied to 0, and WAIT_LOCK waits indefinitely.

Decomposition:
- Package reset_seq_pkg holds:
  - typedef enum logic [1:0] {HOLD, WAIT_LOCK, RELEASE, RUN} reset_seq_state_t;
  - function cnt_width(int a, int b, int c) returning the counter width.
- One sub-module, reset_seq_timer: a clear/enable up-counter with a compare-equal pulse and optional saturation. It is reused for the HOLD, STAGE_DELAY and timeout counts.

Test Plan:
- rst_i high for 5 cycles, then low, lock_i=1 throughout (defaults) -> rst_o=4'b1111 until edge 24; bit0 clears at 25, bit1 at 33, bit2 at 41, bit3 at 49; ready_o=1 at 49; stage_o steps 1,2,3,4.
- lock_i=0 until edge 30, then 1 -> release runs from edge 31; rst_o[0] falls at edge 39; nothing releases before lock.
- lock_i pulsed low for 1 cycle at edge 36 (rst_o=4'b1100) -> rst_o=4'b1111, stage_o=0, ready_o=0 on the next edge; release resumes HOLD_CYCLES+1+STAGE_DELAY edges later.
- rst_i asserted for 1 cycle mid-RELEASE, coinciding with a due stage release -> all outputs reassert; stage_o=0; no bit released on that edge.
- With RESET_SEQ_LOCK_TIMEOUT_EN, LOCK_TIMEOUT=20, lock_i=0 -> err_o=1 exactly 20 edges after entering WAIT_LOCK; rst_o stays 4'b1111; err_o stays 1 after lock_i rises and the sequence completes; rst_i clears it.
- Build without the macro, lock_i=0 for 2000 cycles -> err_o stays 0 and rst_o stays 4'b1111.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {HOLD, WAIT_LOCK, RELEASE, RUN} reset_seq_state_t;

    // Counter width large enough to hold the largest of the three counts.
    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Clear/enable up-counter with compare-equal pulse and optional saturation.
module reset_seq_timer #(
    parameter int W        = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] cmp_i,
    output logic         hit_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (en_i && !(SATURATE && (count_q == '1))) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign hit_o = (count_q == cmp_i);

endmodule

// File: rtl/reset_sequencer.sv
// Staged domain-reset release gated by a lock qualifier.
// Optional lock-timeout error flag: define RESET_SEQ_LOCK_TIMEOUT_EN.
//
// state     | meaning
// HOLD      | all resets asserted, minimum hold period running
// WAIT_LOCK | hold done, waiting for lock_i
// RELEASE   | releasing rst_o bits one per STAGE_DELAY cycles
// RUN       | all resets released, watching for lock loss
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUTS     = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_DELAY  = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              lock_i,
    output logic [NUM_OUTS-1:0]               rst_o,
    output logic [$clog2(NUM_OUTS+1)-1:0]     stage_o,
    output logic                              ready_o,
    output logic                              err_o
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_DELAY, LOCK_TIMEOUT);
    localparam int SW = $clog2(NUM_OUTS + 1);

    if (NUM_OUTS < 1) begin : g_bad_num_outs
        $fatal(1, "reset_sequencer: NUM_OUTS must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $fatal(1, "reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_DELAY < 1) begin : g_bad_stage
        $fatal(1, "reset_sequencer: STAGE_DELAY must be >= 1");
    end
    if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
        $fatal(1, "reset_sequencer: LOCK_TIMEOUT must be >= 1");
    end

    reset_seq_state_t    state_q;
    logic                cnt_clr;
    logic                cnt_en;
    logic [CW-1:0]       cnt_cmp;
    logic                cnt_hit;
    logic [NUM_OUTS-1:0] stage_bit;

    // One counter serves all phases; the compare value follows the state.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        cnt_cmp = CW'(STAGE_DELAY - 1);
        if (rst_i) begin
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    cnt_cmp = CW'(HOLD_CYCLES - 1);
                    cnt_clr = cnt_hit;
                    cnt_en  = !cnt_hit;
                end
                WAIT_LOCK: begin
                    cnt_cmp = CW'(LOCK_TIMEOUT - 1);
                    cnt_clr = lock_i;
                    cnt_en  = !lock_i;
                end
                RELEASE: begin
                    cnt_clr = !lock_i || cnt_hit;
                    cnt_en  = !cnt_clr;
                end
                RUN: begin
                    cnt_clr = !lock_i;
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    reset_seq_timer #(
        .W        (CW),
        .SATURATE (1'b1)
    ) u_timer (
        .clk_i (clk_i),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cmp_i (cnt_cmp),
        .hit_o (cnt_hit)
    );

    assign stage_bit = NUM_OUTS'(1) << stage_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HOLD;
            rst_o   <= '1;
            stage_o <= '0;
            ready_o <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_hit) state_q <= WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lock_i) state_q <= RELEASE;
                end
                RELEASE: begin
                    // Lock loss wins over a release due on the same edge.
                    if (!lock_i) begin
                        state_q <= HOLD;
                        rst_o   <= '1;
                        stage_o <= '0;
                        ready_o <= 1'b0;
                    end else if (cnt_hit) begin
                        rst_o   <= rst_o & ~stage_bit;
                        stage_o <= stage_o + 1'b1;
                        if (stage_o == SW'(NUM_OUTS - 1)) begin
                            ready_o <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!lock_i) begin
                        state_q <= HOLD;
                        rst_o   <= '1;
                        stage_o <= '0;
                        ready_o <= 1'b0;
                    end
                end
                default: begin
                    state_q <= HOLD;
                    rst_o   <= '1;
                    stage_o <= '0;
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
    logic err_q;

    // Sticky: only rst_i clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (state_q == WAIT_LOCK && !lock_i && cnt_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer; timeout checks need RESET_SEQ_LOCK_TIMEOUT_EN.
module tb_reset_sequencer;

    localparam int NO   = 4;
    localparam int HOLD = 16;
    localparam int SD   = 8;
    localparam int TO   = 20;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          lock_i = 1'b1;
    logic [NO-1:0] rst_o;
    logic [2:0]    stage_o;
    logic          ready_o;
    logic          err_o;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    reset_sequencer #(
        .NUM_OUTS     (NO),
        .HOLD_CYCLES  (HOLD),
        .STAGE_DELAY  (SD),
        .LOCK_TIMEOUT (TO)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .lock_i  (lock_i),
        .rst_o   (rst_o),
        .stage_o (stage_o),
        .ready_o (ready_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        edge_n++;
    endtask

    // Expected outputs when RELEASE was entered at edge rel (large = not yet).
    task automatic check_seq(input int rel);
        logic [NO-1:0] exp_rst;
        int            cnt;
        cnt = 0;
        for (int k = 0; k < NO; k++) begin
            exp_rst[k] = !(edge_n >= rel + (k + 1) * SD);
            if (!exp_rst[k]) cnt++;
        end
        check_val("rst_o", 32'(rst_o), 32'(exp_rst));
        check_val("stage_o", 32'(stage_o), 32'(cnt));
        check_val("ready_o", 32'(ready_o), 32'(cnt == NO));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (5) step();
        check_val("rst_rst_o", 32'(rst_o), 32'hF);
        check_val("rst_stage_o", 32'(stage_o), 32'd0);
        check_val("rst_ready_o", 32'(ready_o), 32'd0);
        check_val("rst_err_o", 32'(err_o), 32'd0);
        rst_i  = 1'b0;
        edge_n = 0;
    endtask

    initial begin
        // Lock high throughout: releases at 25, 33, 41, 49.
        lock_i = 1'b1;
        do_reset();
        for (int i = 1; i <= 55; i++) begin
            step();
            check_seq(HOLD + 1);
            check_val("err_nominal", 32'(err_o), 32'd0);
        end

        // Lock arrives late: lock sampled high at edge 31, bit0 falls at 39.
        lock_i = 1'b0;
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            step();
            check_seq(1_000_000);
        end
        lock_i = 1'b1;
        for (int i = 31; i <= 45; i++) begin
            step();
            check_seq(31);
        end
        check_val("late_lock_err", 32'(err_o), 32'd0);

        // One-cycle lock loss sampled at edge 36; release resumes at 61.
        lock_i = 1'b1;
        do_reset();
        for (int i = 1; i <= 35; i++) begin
            step();
            check_seq(HOLD + 1);
        end
        check_val("pre_loss_rst_o", 32'(rst_o), 32'hC);
        lock_i = 1'b0;
        step();
        check_val("loss_rst_o", 32'(rst_o), 32'hF);
        check_val("loss_stage_o", 32'(stage_o), 32'd0);
        check_val("loss_ready_o", 32'(ready_o), 32'd0);
        lock_i = 1'b1;
        for (int i = 37; i <= 70; i++) begin
            step();
            check_seq(53);
        end

        // rst_i on the edge a release of bit1 is due.
        lock_i = 1'b1;
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            step();
            check_seq(HOLD + 1);
        end
        check_val("pre_rst_rst_o", 32'(rst_o), 32'hE);
        rst_i = 1'b1;
        step();
        check_val("mid_rst_rst_o", 32'(rst_o), 32'hF);
        check_val("mid_rst_stage_o", 32'(stage_o), 32'd0);
        check_val("mid_rst_ready_o", 32'(ready_o), 32'd0);
        rst_i  = 1'b0;
        edge_n = 0;
        for (int i = 1; i <= 26; i++) begin
            step();
            check_seq(HOLD + 1);
        end

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
        // WAIT_LOCK entered at edge 16; err_o must rise at edge 36.
        lock_i = 1'b0;
        do_reset();
        for (int i = 1; i <= 35; i++) begin
            step();
            check_val("to_err_early", 32'(err_o), 32'd0);
        end
        step();
        check_val("to_err_set", 32'(err_o), 32'd1);
        check_val("to_rst_o", 32'(rst_o), 32'hF);
        lock_i = 1'b1;
        for (int i = 37; i <= 72; i++) begin
            step();
            check_seq(37);
            check_val("to_err_sticky", 32'(err_o), 32'd1);
        end
        rst_i = 1'b1;
        step();
        check_val("to_err_clear", 32'(err_o), 32'd0);
        rst_i = 1'b0;
`else
        // No timeout logic: waits forever with err_o low.
        lock_i = 1'b0;
        do_reset();
        for (int i = 1; i <= 2000; i++) begin
            step();
            check_val("noto_err_o", 32'(err_o), 32'd0);
            check_val("noto_rst_o", 32'(rst_o), 32'hF);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
